gin_id_config_ctrl: RTL and testbench

//   Sequencer that programs the ID registers of the multicast controllers on one
//   GIN bus (one controller per PE on an X-bus, or one per Y-bus row).

---
 rtl/gin_id_config_ctrl.sv | 89 ++++++++
 tb/tb_gin_id_config_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gin_id_config_ctrl.sv
// Sequencer that writes one ID word into each multicast controller on a GIN bus.
// Takes words in index order and drives the shared ID bus plus a one-hot load strobe.
module gin_id_config_ctrl #(
    parameter int ID_SIZE  = 8,
    parameter int NUM_CTRL = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cfg_valid,
    input  logic [ID_SIZE-1:0]  cfg_id,
    output logic                cfg_ready,
    output logic [NUM_CTRL-1:0] set_id,
    output logic [ID_SIZE-1:0]  id_out,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [NUM_CTRL-1:0]   set_id_nxt;
    logic [ID_SIZE-1:0]    id_nxt;
    logic                  handshake;
    logic                  last_word;

    // Status outputs are pure decodes of the state, so they track it with no extra lag.
    assign cfg_ready = (state == LOAD);
    assign busy      = (state == LOAD);
    assign done      = (state == DONE);

    assign handshake = cfg_valid & cfg_ready;
    assign last_word = (idx == IDX_W'(NUM_CTRL - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        idx_nxt    = idx;
        set_id_nxt = '0;
        id_nxt     = id_out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    id_nxt     = cfg_id;
                    set_id_nxt = NUM_CTRL'(1) << idx;
                    if (last_word) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            set_id <= '0;
            id_out <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            set_id <= set_id_nxt;
            id_out <= id_nxt;
        end
    end

endmodule

// File: tb/tb_gin_id_config_ctrl.sv
// Self-checking bench for gin_id_config_ctrl: a word-counting pass model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_gin_id_config_ctrl;

    localparam int W = 8;
    localparam int N = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cfg_valid;
    logic [W-1:0] cfg_id;
    logic         cfg_ready;
    logic [N-1:0] set_id;
    logic [W-1:0] id_out;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    gin_id_config_ctrl #(.ID_SIZE(W), .NUM_CTRL(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_id    (cfg_id),
        .cfg_ready (cfg_ready),
        .set_id    (set_id),
        .id_out    (id_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Pass model: a pass is "active" until N words have been taken.
    bit           m_active;
    bit           m_done;
    int           m_taken;
    logic [N-1:0] m_set;
    logic [W-1:0] m_id;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 0; m_done = 0; m_taken = 0; m_set = '0; m_id = '0;
            end else begin
                m_set = '0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1; m_done = 0; m_taken = 0;
                    end
                end else if (cfg_valid) begin
                    m_set[m_taken] = 1'b1;
                    m_id    = cfg_id;
                    m_taken = m_taken + 1;
                    if (m_taken == N) begin
                        m_active = 0; m_done = 1;
                    end
                end
            end
            #1;
            vectors++;
            if (set_id !== m_set || id_out !== m_id || busy !== m_active ||
                done !== m_done || cfg_ready !== m_active || !$onehot0(set_id)) begin
                miscompares++;
                $display("FAIL model t=%0t set_id=%h/%h id_out=%h/%h busy=%b/%b done=%b/%b ready=%b/%b (got/exp)",
                         $time, set_id, m_set, id_out, m_id, busy, m_active, done, m_done,
                         cfg_ready, m_active);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then return just after the next posedge settles.
    task automatic drive(input bit s, input bit v, input logic [W-1:0] id, input bit r);
        @(negedge clk);
        start = s; cfg_valid = v; cfg_id = id; rst = r;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] e;
        e = '0;
        e[i] = 1'b1;
        return e;
    endfunction

    int strobes;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_id = '0;

        repeat (3) drive(0, 0, 8'h00, 1);
        check("rst_set_id", 32'(set_id), 0);
        check("rst_id_out", 32'(id_out), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_done",   32'(done),   0);

        // cfg_valid with no pass running is ignored
        drive(0, 1, 8'hAA, 0);
        check("idle_set_id", 32'(set_id), 0);
        check("idle_id_out", 32'(id_out), 0);
        check("idle_ready",  32'(cfg_ready), 0);

        // Back-to-back pass, words 0x00..0x0D
        drive(1, 0, 8'h00, 0);
        check("start_busy",  32'(busy), 1);
        check("start_ready", 32'(cfg_ready), 1);
        for (int i = 0; i < N; i++) begin
            drive(0, 1, W'(i), 0);
            check("b2b_set_id", 32'(set_id), 32'(onehot(i)));
            check("b2b_id_out", 32'(id_out), 32'(i));
        end
        check("b2b_done", 32'(done), 1);
        check("b2b_busy", 32'(busy), 0);
        drive(0, 0, 8'h00, 0);
        check("done_set_clear", 32'(set_id), 0);
        check("done_id_hold",   32'(id_out), 32'h0D);
        check("done_held",      32'(done),   1);

        // Valid toggling 1/0: strobes only follow valid cycles, id holds in gaps
        drive(1, 0, 8'h00, 0);
        check("restart_done_drop", 32'(done), 0);
        strobes = 0;
        for (int i = 0; i < N; i++) begin
            drive(0, 1, W'(8'h40 + i), 0);
            if (set_id != '0) strobes++;
            check("tog_set_id", 32'(set_id), 32'(onehot(i)));
            drive(0, 0, 8'hEE, 0);
            check("tog_gap_set", 32'(set_id), 0);
            check("tog_gap_id",  32'(id_out), 32'(8'h40 + i));
        end
        check("tog_strobes", 32'(strobes), 14);
        check("tog_done",    32'(done), 1);

        // start during LOAD at word 5 is ignored
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < N; i++) begin
            drive(i == 5, 1, W'(8'h60 + i), 0);
            check("mid_start_set", 32'(set_id), 32'(onehot(i)));
            if (i == 12) check("mid_start_busy", 32'(busy), 1);
        end
        check("mid_start_done", 32'(done), 1);
        check("mid_start_id",   32'(id_out), 32'h6D);

        // Reprogram the bank with IDs starting at 0x1F
        drive(1, 0, 8'h00, 0);
        check("reprog_done_drop", 32'(done), 0);
        check("reprog_busy",      32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            drive(0, 1, W'(8'h1F + i), 0);
            check("reprog_set", 32'(set_id), 32'(onehot(i)));
            check("reprog_id",  32'(id_out), 32'(8'h1F + i));
        end
        check("reprog_done", 32'(done), 1);

        // Reset at word 7 aborts the pass; the next pass starts again at controller 0
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, W'(8'h80 + i), 0);
        drive(0, 1, 8'h99, 1);
        check("abort_set_id", 32'(set_id), 0);
        check("abort_id_out", 32'(id_out), 0);
        check("abort_busy",   32'(busy),   0);
        check("abort_done",   32'(done),   0);
        repeat (2) drive(0, 1, 8'h99, 1);
        drive(0, 0, 8'h00, 0);
        check("abort_idle_done", 32'(done), 0);
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h70, 0);
        check("abort_first_set", 32'(set_id), 32'(onehot(0)));
        check("abort_first_id",  32'(id_out), 32'h70);
        for (int i = 1; i < N; i++) drive(0, 1, W'(8'h70 + i), 0);
        check("abort_pass_done", 32'(done), 1);
        drive(0, 0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
